// File: rtl/tlc_phase_sequencer.sv
// Highway/farm-road traffic-light phase sequencer: owns the phase FSM, the
// prescaled phase timer, the farm-road request latch and the active-low lamp pads.
module tlc_phase_sequencer #(
    parameter int TICK_DIV   = 16,
    parameter int TW         = 8,
    parameter int T_HWY_MIN  = 16,
    parameter int T_FARM_MAX = 8,
    parameter int T_YLW      = 3,
    parameter int T_ALLRED   = 1
) (
    input  logic       CLK_pad,
    input  logic       RSTN_pad,
    input  logic       CLR_pad,
    input  logic       FM_pad,
    input  logic       TEST_pad,
    output logic       GRN1_pad,
    output logic       YLW1_pad,
    output logic       RED1_pad,
    output logic       GRN2_pad,
    output logic       YLW2_pad,
    output logic       RED2_pad,
    output logic [2:0] PHASE_o,
    output logic       TICK_o
);

    typedef enum logic [2:0] {
        HGRN  = 3'd0,
        HYLW  = 3'd1,
        ARED1 = 3'd2,
        FGRN  = 3'd3,
        FYLW  = 3'd4,
        ARED2 = 3'd5
    } state_t;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PR_LAST   = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] HWY_LAST  = TW'(T_HWY_MIN - 1);
    localparam logic [TW-1:0] FARM_LAST = TW'(T_FARM_MAX - 1);
    localparam logic [TW-1:0] YLW_LAST  = TW'(T_YLW - 1);
    localparam logic [TW-1:0] ARED_LAST = TW'(T_ALLRED - 1);
    localparam logic [TW-1:0] TMR_MAX   = '1;

    logic [1:0]    rst_sync;
    logic          rst_n;
    logic [1:0]    fm_sync;
    logic [1:0]    test_sync;
    logic          fm_s;
    logic          test_s;
    logic [PW-1:0] pr;
    logic          tick;
    logic [TW-1:0] timer;
    logic          fm_req;
    logic [2:0]    state;
    state_t        next_state;
    logic          state_change;
    logic          enter_fgrn;

    // Reset asserts immediately but is released only after two clean clock edges.
    always_ff @(posedge CLK_pad or negedge RSTN_pad) begin
        if (!RSTN_pad) rst_sync <= 2'b00;
        else           rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    // Input synchronizers are deliberately left out of the synchronous clear.
    always_ff @(posedge CLK_pad or negedge rst_n) begin
        if (!rst_n) begin
            fm_sync   <= 2'b00;
            test_sync <= 2'b00;
        end else begin
            fm_sync   <= {fm_sync[0], FM_pad};
            test_sync <= {test_sync[0], TEST_pad};
        end
    end
    assign fm_s   = fm_sync[1];
    assign test_s = test_sync[1];

    assign tick   = (test_s || (pr == PR_LAST)) && !CLR_pad;
    assign TICK_o = tick;

    always_ff @(posedge CLK_pad or negedge rst_n) begin
        if (!rst_n)                pr <= '0;
        else if (CLR_pad || test_s) pr <= '0;
        else if (pr == PR_LAST)    pr <= '0;
        else                       pr <= pr + PW'(1);
    end

    always_comb begin
        next_state = state_t'(state);
        case (state)
            HGRN:    if (tick && fm_req && (timer >= HWY_LAST)) next_state = HYLW;
            HYLW:    if (tick && (timer == YLW_LAST))           next_state = ARED1;
            ARED1:   if (tick && (timer == ARED_LAST))          next_state = FGRN;
            FGRN:    if (tick && ((timer == FARM_LAST) || (!fm_s && (timer != '0))))
                         next_state = FYLW;
            FYLW:    if (tick && (timer == YLW_LAST))           next_state = ARED2;
            ARED2:   if (tick && (timer == ARED_LAST))          next_state = HGRN;
            default: next_state = HGRN;
        endcase
    end

    assign state_change = (next_state != state);
    assign enter_fgrn   = (next_state == FGRN) && (state != FGRN);

    always_ff @(posedge CLK_pad or negedge rst_n) begin
        if (!rst_n)       state <= HGRN;
        else if (CLR_pad) state <= HGRN;
        else              state <= next_state;
    end

    always_ff @(posedge CLK_pad or negedge rst_n) begin
        if (!rst_n)                     timer <= '0;
        else if (CLR_pad)               timer <= '0;
        else if (state_change)          timer <= '0;
        else if (tick && timer != TMR_MAX) timer <= timer + TW'(1);
    end

    // Clear wins over a simultaneous set when the farm green is granted.
    always_ff @(posedge CLK_pad or negedge rst_n) begin
        if (!rst_n)          fm_req <= 1'b0;
        else if (CLR_pad)    fm_req <= 1'b0;
        else if (enter_fgrn) fm_req <= 1'b0;
        else if (fm_s)       fm_req <= 1'b1;
    end

    assign PHASE_o = state;

    always_comb begin
        GRN1_pad = 1'b1;
        YLW1_pad = 1'b1;
        RED1_pad = 1'b0;
        GRN2_pad = 1'b1;
        YLW2_pad = 1'b1;
        RED2_pad = 1'b0;
        case (state)
            HGRN: begin
                GRN1_pad = 1'b0;
                RED1_pad = 1'b1;
            end
            HYLW: begin
                YLW1_pad = 1'b0;
                RED1_pad = 1'b1;
            end
            FGRN: begin
                GRN2_pad = 1'b0;
                RED2_pad = 1'b1;
            end
            FYLW: begin
                YLW2_pad = 1'b0;
                RED2_pad = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tlc_phase_sequencer.sv
// Bench for tlc_phase_sequencer: expected phase segments (phase, length) are
// queued by the stimulus and checked by a monitor on every phase change.
module tb_tlc_phase_sequencer;

    logic       clk = 1'b0;
    logic       rstn_pad;
    logic       clr_pad;
    logic       fm_pad;
    logic       test_pad;
    logic       grn1, ylw1, red1, grn2, ylw2, red2;
    logic [2:0] phase;
    logic       tick_o;
    logic [5:0] lamps;

    localparam logic [5:0] L_HGRN = 6'b011110;
    localparam logic [5:0] L_FGRN = 6'b110011;
    localparam logic [5:0] L_BAD  = 6'b110110;

    int checks = 0;
    int errors = 0;
    int viol   = 0;
    logic        mon_en = 1'b0;
    logic [2:0]  cur_phase = 3'd0;
    int          cur_len = 0;
    logic [15:0] exp_q[$];

    tlc_phase_sequencer dut (
        .CLK_pad  (clk),
        .RSTN_pad (rstn_pad),
        .CLR_pad  (clr_pad),
        .FM_pad   (fm_pad),
        .TEST_pad (test_pad),
        .GRN1_pad (grn1),
        .YLW1_pad (ylw1),
        .RED1_pad (red1),
        .GRN2_pad (grn2),
        .YLW2_pad (ylw2),
        .RED2_pad (red2),
        .PHASE_o  (phase),
        .TICK_o   (tick_o)
    );

    assign lamps = {grn1, ylw1, red1, grn2, ylw2, red2};

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
        end
    endtask

    // Length 0 means the segment length is not checked.
    task automatic exp_seg(input logic [2:0] ph, input int len);
        exp_q.push_back({ph, 13'(len)});
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout pending=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_phase(input logic [2:0] ph, input int budget);
        int n = 0;
        @(negedge clk);
        while (phase != ph && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (phase != ph) begin
            checks++;
            errors++;
            $display("FAIL wait_phase actual=%0d required=%0d", phase, ph);
        end
    endtask

    task automatic do_reset();
        mon_en   = 1'b0;
        rstn_pad = 1'b0;
        repeat (3) @(negedge clk);
        rstn_pad = 1'b1;
    endtask

    task automatic hold_hgrn(input string name, input int cycles);
        int bad = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (phase != 3'd0 || lamps != L_HGRN) bad++;
        end
        chk(name, bad, 0);
    endtask

    // Monitor: closes a segment whenever PHASE_o changes and checks it.
    always @(negedge clk) begin
        logic [15:0] e;
        if (phase !== cur_phase) begin
            if (mon_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL seg_unexpected phase=%0d len=%0d", cur_phase, cur_len);
                end else begin
                    e = exp_q.pop_front();
                    if (e[15:13] != cur_phase || (e[12:0] != 13'd0 && int'(e[12:0]) != cur_len)) begin
                        errors++;
                        $display("FAIL seg phase=%0d len=%0d required phase=%0d len=%0d",
                                 cur_phase, cur_len, e[15:13], e[12:0]);
                    end
                end
            end
            cur_phase = phase;
            cur_len   = 1;
        end else begin
            cur_len++;
        end
        if ((!grn1 && !grn2) || (red1 && red2)) viol++;
    end

    initial begin
        int cnt;
        rstn_pad = 1'b0;
        clr_pad  = 1'b0;
        fm_pad   = 1'b0;
        test_pad = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_lamps", lamps, L_HGRN);
        chk("rst_phase", phase, 0);
        chk("rst_tick", tick_o, 0);

        // Full cycle in test mode with the sensor held high
        test_pad = 1'b1;
        fm_pad   = 1'b1;
        exp_seg(3'd0, 0);
        exp_seg(3'd1, 3);
        exp_seg(3'd2, 1);
        exp_seg(3'd3, 8);
        exp_seg(3'd4, 3);
        exp_seg(3'd5, 1);
        exp_seg(3'd0, 16);
        exp_seg(3'd1, 3);
        exp_seg(3'd2, 1);
        exp_seg(3'd3, 8);
        do_reset();
        mon_en = 1'b1;
        drain("full_cycle", 300);
        mon_en = 1'b0;

        // Asynchronous reset in the middle of farm green
        wait_phase(3'd3, 100);
        #2;
        rstn_pad = 1'b0;
        fm_pad   = 1'b0;
        #1;
        chk("async_rst_lamps", lamps, L_HGRN);
        chk("async_rst_phase", phase, 0);
        repeat (3) @(negedge clk);
        rstn_pad = 1'b1;
        hold_hgrn("rst_hold", 40);

        // Short sensor pulse: farm green lasts the 2-tick minimum
        test_pad = 1'b1;
        fm_pad   = 1'b0;
        do_reset();
        repeat (30) @(negedge clk);
        exp_seg(3'd0, 0);
        exp_seg(3'd1, 3);
        exp_seg(3'd2, 1);
        exp_seg(3'd3, 2);
        exp_seg(3'd4, 3);
        exp_seg(3'd5, 1);
        mon_en = 1'b1;
        fm_pad = 1'b1;
        repeat (5) @(negedge clk);
        fm_pad = 1'b0;
        drain("early_exit", 100);
        hold_hgrn("early_exit_hold", 40);
        mon_en = 1'b0;

        // Normal mode: prescaled ticks
        test_pad = 1'b0;
        fm_pad   = 1'b1;
        exp_seg(3'd0, 0);
        exp_seg(3'd1, 48);
        exp_seg(3'd2, 16);
        exp_seg(3'd3, 128);
        exp_seg(3'd4, 48);
        exp_seg(3'd5, 16);
        exp_seg(3'd0, 256);
        do_reset();
        mon_en = 1'b1;
        cnt = 0;
        while (tick_o !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        chk("first_tick", tick_o, 1);
        for (int k = 0; k < 3; k++) begin
            cnt = 0;
            do begin
                @(negedge clk);
                cnt++;
            end while (tick_o !== 1'b1 && cnt < 40);
            chk("tick_period", cnt, 16);
        end
        drain("prescaler", 1500);
        mon_en = 1'b0;

        // Synchronous clear during ARED1
        test_pad = 1'b1;
        fm_pad   = 1'b1;
        do_reset();
        wait_phase(3'd1, 100);
        fm_pad = 1'b0;
        wait_phase(3'd2, 10);
        clr_pad = 1'b1;
        #1;
        chk("clr_tick", tick_o, 0);
        @(negedge clk);
        clr_pad = 1'b0;
        chk("clr_phase", phase, 0);
        chk("clr_timer", int'(dut.timer), 0);
        chk("clr_fm_req", int'(dut.fm_req), 0);
        hold_hgrn("clr_hold", 40);

        // Illegal state code
        @(negedge clk);
        force dut.state = 3'd6;
        #1;
        chk("illegal_lamps", lamps, L_BAD);
        chk("illegal_phase", phase, 6);
        release dut.state;
        @(posedge clk);
        #1;
        chk("illegal_recover", phase, 0);

        // Lamp decode for farm green
        fm_pad = 1'b1;
        wait_phase(3'd3, 100);
        #1;
        chk("fgrn_lamps", lamps, L_FGRN);

        @(negedge clk);
        chk("safety_violations", viol, 0);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
